// File: rtl/sync_req_arb.sv
// -----------------------------------------------------------------------------
// sync_req_arb
//   Upstream feeder of the dnoc sync collector. Per-node sync request pulses are
//   captured into pending flags, arbitrated round-robin onto a single
//   sync_req/sync_node_id channel, and acknowledged when the collector accepts
//   them. When the collector reports a completed round (sync_hit), every node
//   accepted in that round receives a one-cycle release pulse.
//
// Ports:
//   clk               clock
//   rst_n             asynchronous active-low reset
//   node_sync_req     [NODE_NUM] per-node request pulse/level
//   node_sync_ack     [NODE_NUM] one-cycle pulse, node's request accepted
//   node_sync_release [NODE_NUM] one-cycle pulse, round complete for node
//   sync_req          request to collector
//   sync_node_id      [ID_W] node index of current request
//   sync_gnt          collector ready; transfer when sync_req && sync_gnt
//   sync_hit          collector round complete (one-cycle pulse)
// -----------------------------------------------------------------------------
module sync_req_arb #(
    parameter int NODE_NUM = 12,
    parameter int ID_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NODE_NUM-1:0] node_sync_req,
    output logic [NODE_NUM-1:0] node_sync_ack,
    output logic [NODE_NUM-1:0] node_sync_release,
    output logic                sync_req,
    output logic [ID_W-1:0]     sync_node_id,
    input  logic                sync_gnt,
    input  logic                sync_hit
);

    logic [NODE_NUM-1:0] pending_r;
    logic [NODE_NUM-1:0] accepted_r;
    logic [NODE_NUM-1:0] ack_r;
    logic [NODE_NUM-1:0] release_r;
    logic [ID_W-1:0]     rr_ptr_r;

    logic [NODE_NUM-1:0] eligible_s;
    logic                found_hi_s;
    logic                found_lo_s;
    logic [ID_W-1:0]     win_hi_s;
    logic [ID_W-1:0]     win_lo_s;
    logic [ID_W-1:0]     win_s;
    logic [NODE_NUM-1:0] win_oh_s;
    logic                xfer_s;
    logic [NODE_NUM-1:0] clr_s;

    logic [NODE_NUM-1:0] pending_nxt_s;
    logic [NODE_NUM-1:0] accepted_nxt_s;
    logic [NODE_NUM-1:0] release_nxt_s;
    logic [ID_W-1:0]     rr_ptr_nxt_s;

    // Round-robin pick from registered state only. The scan runs downward so
    // the last hit kept is the lowest index: win_hi is the lowest eligible
    // index at or above rr_ptr, win_lo the lowest eligible overall (the wrap).
    always_comb begin
        eligible_s = pending_r & ~accepted_r;
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        win_hi_s   = {ID_W{1'b0}};
        win_lo_s   = {ID_W{1'b0}};
        for (int i = NODE_NUM - 1; i >= 0; i--) begin
            if (eligible_s[i]) begin
                found_lo_s = 1'b1;
                win_lo_s   = ID_W'(i);
                if (ID_W'(i) >= rr_ptr_r) begin
                    found_hi_s = 1'b1;
                    win_hi_s   = ID_W'(i);
                end else begin
                    found_hi_s = found_hi_s;
                end
            end else begin
                found_lo_s = found_lo_s;
            end
        end
        if (found_hi_s) begin
            win_s = win_hi_s;
        end else begin
            win_s = win_lo_s;
        end
    end

    assign sync_req          = found_lo_s;
    assign sync_node_id      = win_s;
    assign node_sync_ack     = ack_r;
    assign node_sync_release = release_r;

    // Next-state: capture, transfer bookkeeping and round release.
    always_comb begin
        win_oh_s = {{(NODE_NUM-1){1'b0}}, 1'b1} << win_s;
        xfer_s   = found_lo_s & sync_gnt;
        if (xfer_s) begin
            clr_s        = win_oh_s;
            rr_ptr_nxt_s = (win_s == ID_W'(NODE_NUM - 1)) ? {ID_W{1'b0}} : win_s + {{(ID_W-1){1'b0}}, 1'b1};
        end else begin
            clr_s        = {NODE_NUM{1'b0}};
            rr_ptr_nxt_s = rr_ptr_r;
        end
        // A request seen in the transfer cycle survives as a next-round request.
        pending_nxt_s = (pending_r & ~clr_s) | node_sync_req;
        // Clear-then-set: a winner in the hit cycle joins the next round.
        if (sync_hit) begin
            accepted_nxt_s = clr_s;
            release_nxt_s  = accepted_r;
        end else begin
            accepted_nxt_s = accepted_r | clr_s;
            release_nxt_s  = {NODE_NUM{1'b0}};
        end
    end

    // State and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= {NODE_NUM{1'b0}};
            accepted_r <= {NODE_NUM{1'b0}};
            ack_r      <= {NODE_NUM{1'b0}};
            release_r  <= {NODE_NUM{1'b0}};
            rr_ptr_r   <= {ID_W{1'b0}};
        end else begin
            pending_r  <= pending_nxt_s;
            accepted_r <= accepted_nxt_s;
            ack_r      <= clr_s;
            release_r  <= release_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
        end
    end

endmodule
